usb_packet_buffer_arbiter: RTL and testbench

- Owns the single-port USB packet buffer and shares it between two requesters:
  - the USB receive front end, which writes 32-bit words of an incoming packet;
  - the CPU load/store path, which reads and writes the buffer.
- Enforces the ownership handoff. A completed packet passes ownership to the CPU and raises the external interrupt. The CPU hands the buffer back with an explicit release.
- Packets arriving while the CPU owns the buffer are dropped whole, never partially written.

---
 rtl/usb_packet_buffer_arbiter_if.sv | 51 +++++
 rtl/usb_packet_buffer_arbiter.sv | 119 +++++++++++
 tb/tb_usb_packet_buffer_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_packet_buffer_arbiter_if.sv
// Signal bundle between the USB packet buffer arbiter, its two requesters
// (USB receive front end, CPU load/store path) and the single-port buffer RAM.
interface usb_packet_buffer_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  usb_req;
  logic [ADDR_WIDTH-1:0] usb_addr;
  logic [DATA_WIDTH-1:0] usb_wdata;
  logic                  usb_packet_done;
  logic                  usb_grant;

  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_release;
  logic                  cpu_grant;
  logic                  cpu_ready;
  logic [DATA_WIDTH-1:0] cpu_rdata;

  logic                  packet_irq;
  logic [ADDR_WIDTH:0]   packet_length;
  logic [15:0]           overrun_count;

  logic                  buf_en;
  logic                  buf_we;
  logic [ADDR_WIDTH-1:0] buf_addr;
  logic [DATA_WIDTH-1:0] buf_wdata;
  logic [DATA_WIDTH-1:0] buf_rdata;

  modport slave (
    input  usb_req, usb_addr, usb_wdata, usb_packet_done,
    output usb_grant,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_release,
    output cpu_grant, cpu_ready, cpu_rdata,
    output packet_irq, packet_length, overrun_count,
    output buf_en, buf_we, buf_addr, buf_wdata,
    input  buf_rdata
  );

  modport master (
    output usb_req, usb_addr, usb_wdata, usb_packet_done,
    input  usb_grant,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_release,
    input  cpu_grant, cpu_ready, cpu_rdata,
    input  packet_irq, packet_length, overrun_count,
    input  buf_en, buf_we, buf_addr, buf_wdata,
    output buf_rdata
  );
endinterface

// File: rtl/usb_packet_buffer_arbiter.sv
// Ownership arbiter for the single-port USB packet buffer (USB writer vs CPU).
// Optional feature macro: USB_BUFFER_OVERRUN_COUNT_EN enables the dropped-packet counter.
module usb_packet_buffer_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input logic                        clock48,
  input logic                        reset,
  usb_packet_buffer_arbiter_if.slave bus
);

  typedef enum logic {STATE_USB_OWN, STATE_CPU_OWN} state_t;

  localparam logic [ADDR_WIDTH:0] WC_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t              state_q, state_d;
  logic                dropping_q, dropping_d;
  logic [ADDR_WIDTH:0] word_count_q, word_count_d;
  logic [ADDR_WIDTH:0] packet_length_q, packet_length_d;
  logic                cpu_ready_q;

  logic                usb_grant;
  logic                usb_wr;
  logic                cpu_grant;

  function automatic logic [ADDR_WIDTH:0] wc_inc(input logic [ADDR_WIDTH:0] v);
    return (v == WC_MAX) ? v : v + 1'b1;
  endfunction

  // usb_grant only asserts when the front end actually presents a word or a done.
  always_comb begin
    state_d         = state_q;
    dropping_d      = dropping_q;
    word_count_d    = word_count_q;
    packet_length_d = packet_length_q;
    usb_grant       = 1'b0;
    usb_wr          = 1'b0;
    cpu_grant       = 1'b0;

    if (state_q == STATE_USB_OWN) begin
      usb_grant = !dropping_q && (bus.usb_req || bus.usb_packet_done);
      usb_wr    = bus.usb_req && usb_grant;
      cpu_grant = bus.cpu_req && !usb_wr;
      if (usb_wr) begin
        word_count_d = wc_inc(word_count_q);
      end
      if (bus.usb_packet_done && usb_grant) begin
        packet_length_d = word_count_d;
        word_count_d    = '0;
        state_d         = STATE_CPU_OWN;
      end else if (bus.usb_packet_done && dropping_q) begin
        dropping_d = 1'b0;
      end
    end else begin
      cpu_grant = bus.cpu_req;
      // A done closes the dropped packet even if a new word arrives with it.
      if (bus.usb_packet_done) begin
        dropping_d = 1'b0;
      end else if (bus.usb_req) begin
        dropping_d = 1'b1;
      end
      if (bus.cpu_release) begin
        state_d = STATE_USB_OWN;
      end
    end
  end

  always_ff @(posedge clock48 or posedge reset) begin
    if (reset) begin
      state_q         <= STATE_USB_OWN;
      dropping_q      <= 1'b0;
      word_count_q    <= '0;
      packet_length_q <= '0;
      cpu_ready_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      dropping_q      <= dropping_d;
      word_count_q    <= word_count_d;
      packet_length_q <= packet_length_d;
      cpu_ready_q     <= cpu_grant;
    end
  end

`ifdef USB_BUFFER_OVERRUN_COUNT_EN
  logic [15:0] overrun_q;
  logic        drop_event;

  function automatic logic [15:0] ovr_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign drop_event = bus.usb_packet_done && ((state_q == STATE_CPU_OWN) || dropping_q);

  always_ff @(posedge clock48 or posedge reset) begin
    if (reset) begin
      overrun_q <= '0;
    end else if (drop_event) begin
      overrun_q <= ovr_inc(overrun_q);
    end
  end

  assign bus.overrun_count = overrun_q;
`else
  assign bus.overrun_count = '0;
`endif

  assign bus.usb_grant     = usb_grant;
  assign bus.cpu_grant     = cpu_grant;
  assign bus.cpu_ready     = cpu_ready_q;
  assign bus.cpu_rdata     = bus.buf_rdata;
  assign bus.packet_irq    = (state_q == STATE_CPU_OWN);
  assign bus.packet_length = packet_length_q;

  assign bus.buf_en    = usb_wr || cpu_grant;
  assign bus.buf_we    = usb_wr || (cpu_grant && bus.cpu_we);
  assign bus.buf_addr  = usb_wr ? bus.usb_addr  : bus.cpu_addr;
  assign bus.buf_wdata = usb_wr ? bus.usb_wdata : bus.cpu_wdata;

endmodule

// File: tb/tb_usb_packet_buffer_arbiter.sv
// Self-checking bench for usb_packet_buffer_arbiter: directed scenarios plus
// randomized traffic compared every cycle against a behavioural ownership model.
module tb_usb_packet_buffer_arbiter;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;
`ifdef USB_BUFFER_OVERRUN_COUNT_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic clock48 = 1'b0;
  logic reset   = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock48 = ~clock48;

  usb_packet_buffer_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  usb_packet_buffer_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock48 (clock48),
    .reset   (reset),
    .bus     (bus)
  );

  // Synchronous single-port buffer RAM.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clock48) begin
    if (bus.buf_en) begin
      if (bus.buf_we) ram[bus.buf_addr] = bus.buf_wdata;
      else            bus.buf_rdata <= ram[bus.buf_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the buffer, and what each cycle must do.
  bit            m_cpu_owns = 1'b0;
  bit            m_drop     = 1'b0;
  int            m_wc       = 0;
  int            m_len      = 0;
  int            m_ovr      = 0;
  bit            m_ready    = 1'b0;
  bit            m_rd_pend  = 1'b0;
  logic [DW-1:0] m_rd       = '0;
  logic [DW-1:0] m_mem [DEPTH];

  always @(negedge clock48) begin
    bit ug, uw, cg;
    int nwc;
    if (reset) begin
      m_cpu_owns = 0; m_drop = 0; m_wc = 0; m_len = 0; m_ovr = 0;
      m_ready = 0; m_rd_pend = 0;
    end
    ug = !m_cpu_owns && !m_drop && (bus.usb_req || bus.usb_packet_done);
    uw = ug && bus.usb_req;
    cg = bus.cpu_req && !uw;
    chk("usb_grant", bus.usb_grant, ug);
    chk("cpu_grant", bus.cpu_grant, cg);
    chk("buf_en", bus.buf_en, uw || cg);
    if (uw) begin
      chk("buf_we_usb", bus.buf_we, 1);
      chk("buf_addr_usb", bus.buf_addr, bus.usb_addr);
      chk("buf_wdata_usb", bus.buf_wdata, bus.usb_wdata);
    end else if (cg) begin
      chk("buf_we_cpu", bus.buf_we, bus.cpu_we);
      chk("buf_addr_cpu", bus.buf_addr, bus.cpu_addr);
      if (bus.cpu_we) chk("buf_wdata_cpu", bus.buf_wdata, bus.cpu_wdata);
    end
    chk("packet_irq", bus.packet_irq, m_cpu_owns);
    chk("packet_length", bus.packet_length, m_len);
    chk("overrun_count", bus.overrun_count, OVR_EN ? m_ovr : 0);
    chk("cpu_ready", bus.cpu_ready, m_ready);
    if (m_ready && m_rd_pend) chk("cpu_rdata", bus.cpu_rdata, m_rd);

    if (!reset) begin
      m_ready   = cg;
      m_rd_pend = cg && !bus.cpu_we;
      if (cg && !bus.cpu_we) m_rd = m_mem[bus.cpu_addr];
      if (uw) m_mem[bus.usb_addr] = bus.usb_wdata;
      else if (cg && bus.cpu_we) m_mem[bus.cpu_addr] = bus.cpu_wdata;
      if (!m_cpu_owns) begin
        nwc = uw ? ((m_wc + 1 > DEPTH) ? DEPTH : m_wc + 1) : m_wc;
        if (ug && bus.usb_packet_done) begin
          m_len = nwc; m_wc = 0; m_cpu_owns = 1;
        end else begin
          m_wc = nwc;
          if (m_drop && bus.usb_packet_done) begin
            m_ovr  = (m_ovr == 65535) ? m_ovr : m_ovr + 1;
            m_drop = 0;
          end
        end
      end else begin
        if (bus.usb_packet_done) begin
          m_ovr  = (m_ovr == 65535) ? m_ovr : m_ovr + 1;
          m_drop = 0;
        end else if (bus.usb_req) begin
          m_drop = 1;
        end
        if (bus.cpu_release) m_cpu_owns = 0;
      end
    end
  end

  task automatic idle();
    bus.usb_req = 0; bus.usb_addr = '0; bus.usb_wdata = '0; bus.usb_packet_done = 0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.cpu_release = 0;
  endtask

  task automatic tick();
    @(posedge clock48);
    #1;
  endtask

  task automatic usb_word(input int a, input int d, input bit done);
    idle();
    bus.usb_req = 1; bus.usb_addr = a[AW-1:0]; bus.usb_wdata = d; bus.usb_packet_done = done;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = '0; m_mem[i] = '0;
    end
    bus.buf_rdata = '0;
    idle();
    tick(); tick();
    chk("rst_irq", bus.packet_irq, 0);
    chk("rst_len", bus.packet_length, 0);
    chk("rst_ovr", bus.overrun_count, 0);
    chk("rst_ready", bus.cpu_ready, 0);
    chk("rst_ugrant", bus.usb_grant, 0);
    chk("rst_cgrant", bus.cpu_grant, 0);
    reset = 0;

    // First packet: 4 words, done on the last.
    for (int i = 0; i < 4; i++) begin
      usb_word(i, 32'hA0 + i, i == 3);
      #1 chk("p1_ugrant", bus.usb_grant, 1);
      chk("p1_bufen", bus.buf_en, 1);
      tick();
    end
    idle();
    #1 chk("p1_len", bus.packet_length, 4);
    chk("p1_irq", bus.packet_irq, 1);
    bus.cpu_release = 1;
    tick();
    idle();
    #1 chk("rel_irq", bus.packet_irq, 0);

    // CPU read loses to a simultaneous USB write, then fills the idle cycle.
    usb_word(10, 32'h55, 0);
    bus.cpu_req = 1; bus.cpu_addr = 2;
    #1 chk("arb_cgrant0", bus.cpu_grant, 0);
    tick();
    idle();
    bus.cpu_req = 1; bus.cpu_addr = 2;
    #1 chk("arb_cgrant1", bus.cpu_grant, 1);
    tick();
    idle();
    #1 chk("arb_ready", bus.cpu_ready, 1);
    chk("arb_rdata", bus.cpu_rdata, 32'hA2);
    usb_word(11, 32'hB1, 1);
    tick();
    idle();
    #1 chk("p2_len", bus.packet_length, 2);

    // Packet arriving while the CPU owns the buffer is dropped.
    for (int i = 0; i < 3; i++) begin
      usb_word(30 + i, 32'hC0 + i, i == 2);
      #1 chk("drop_ugrant", bus.usb_grant, 0);
      chk("drop_bufen", bus.buf_en, 0);
      tick();
    end
    idle();
    #1 chk("drop_ovr", bus.overrun_count, OVR_EN ? 1 : 0);
    chk("drop_irq", bus.packet_irq, 1);

    // Release in the middle of a 6-word packet: its tail stays dropped.
    for (int i = 0; i < 6; i++) begin
      usb_word(40 + i, 32'hD0 + i, i == 5);
      if (i == 2) bus.cpu_release = 1;
      #1 chk("mid_ugrant", bus.usb_grant, 0);
      tick();
    end
    idle();
    #1 chk("mid_ovr", bus.overrun_count, OVR_EN ? 2 : 0);
    chk("mid_irq", bus.packet_irq, 0);
    for (int i = 0; i < 2; i++) begin
      usb_word(50 + i, 32'hE0 + i, i == 1);
      #1 chk("next_ugrant", bus.usb_grant, 1);
      tick();
    end
    idle();
    bus.cpu_req = 1; bus.cpu_addr = 43;
    #1 chk("next_len", bus.packet_length, 2);
    tick();
    idle();
    #1 chk("mid_unwritten", bus.cpu_rdata, 0);

    // Release and done together.
    bus.cpu_release = 1; bus.usb_packet_done = 1;
    tick();
    idle();
    #1 chk("both_irq", bus.packet_irq, 0);
    chk("both_ovr", bus.overrun_count, OVR_EN ? 3 : 0);

    // Word count saturates at the buffer depth.
    for (int i = 0; i < DEPTH + 4; i++) begin
      usb_word(i, i, i == DEPTH + 3);
      tick();
    end
    idle();
    #1 chk("sat_len", bus.packet_length, DEPTH);
    bus.cpu_release = 1;
    tick();

    // Reset in the middle of a packet.
    for (int i = 0; i < 2; i++) begin
      usb_word(60 + i, 32'hF0 + i, 0);
      tick();
    end
    idle();
    reset = 1;
    #1 chk("mr_irq", bus.packet_irq, 0);
    chk("mr_len", bus.packet_length, 0);
    chk("mr_ovr", bus.overrun_count, 0);
    chk("mr_ready", bus.cpu_ready, 0);
    chk("mr_bufen", bus.buf_en, 0);
    tick();
    reset = 0;
    usb_word(62, 32'hF2, 0);
    #1 chk("mr_ugrant", bus.usb_grant, 1);
    tick();

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      idle();
      if ($urandom_range(0, 799) == 0) begin
        reset = 1;
        tick();
        reset = 0;
        continue;
      end
      bus.usb_req         = ($urandom_range(0, 1) == 0);
      bus.usb_addr        = AW'($urandom_range(0, DEPTH - 1));
      bus.usb_wdata       = $urandom;
      bus.usb_packet_done = ($urandom_range(0, 7) == 0);
      bus.cpu_req         = ($urandom_range(0, 1) == 0);
      bus.cpu_we          = ($urandom_range(0, 2) == 0);
      bus.cpu_addr        = AW'($urandom_range(0, DEPTH - 1));
      bus.cpu_wdata       = $urandom;
      bus.cpu_release     = ($urandom_range(0, 9) == 0);
      tick();
    end
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
